// File: rtl/video_pkg.sv
// Shared VGA timing defaults, pattern IDs and colour-bar lookup
// for the animated test pattern generator.
package video_pkg;

   localparam int VGA_VIDEO_WIDTH = 3;
   localparam int VGA_TOTAL_COLS  = 800;
   localparam int VGA_TOTAL_ROWS  = 525;
   localparam int VGA_ACTIVE_COLS = 640;
   localparam int VGA_ACTIVE_ROWS = 480;

   typedef enum logic [3:0] {
      PAT_OFF    = 4'd0,
      PAT_RED    = 4'd1,
      PAT_GRN    = 4'd2,
      PAT_BLU    = 4'd3,
      PAT_CHECK  = 4'd4,
      PAT_BARS   = 4'd5,
      PAT_BORDER = 4'd6,
      PAT_RAMP   = 4'd7,
      PAT_BOX    = 4'd8,
      PAT_SCROLL = 4'd9
   } pat_e;

   // Bar index -> {R,G,B} full-scale enables.
   function automatic logic [2:0] bar_rgb(input logic [2:0] idx);
      return {idx[2], idx[1], idx[0]};
   endfunction

endpackage

// File: rtl/box_bouncer.sv
// One axis of the bouncing box: position/direction registers that
// step once per frame and reflect off 0 and LIMIT.
//  clk_i  pixel clock       rst_i  sync reset, active-high
//  step_i advance one step  pos_o  current position
module box_bouncer #(
   parameter int LIMIT = 608,
   parameter int STEP  = 2
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       step_i,
   output logic [9:0] pos_o
);

   logic [9:0]  pos_q, pos_d;
   logic        dir_q, dir_d;
   logic [10:0] up;

   always_comb begin
      pos_d = pos_q;
      dir_d = dir_q;
      up    = {1'b0, pos_q} + 11'(STEP);
      if (step_i) begin
         if (dir_q) begin
            if (up > 11'(LIMIT)) begin
               pos_d = 10'(LIMIT);
               dir_d = 1'b0;
            end else begin
               pos_d = up[9:0];
            end
         end else begin
            if (pos_q < 10'(STEP)) begin
               pos_d = '0;
               dir_d = 1'b1;
            end else begin
               pos_d = pos_q - 10'(STEP);
            end
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         pos_q <= '0;
         dir_q <= 1'b1;
      end else begin
         pos_q <= pos_d;
         dir_q <= dir_d;
      end
   end

   assign pos_o = pos_q;

endmodule

// File: rtl/animated_pattern_gen.sv
// Test pattern generator with animated ramp/box/scroll patterns.
//  i_Clk, i_Rst (sync, active-high); i_Pattern latched at frame start
//  i_HSync/i_VSync in, o_HSync/o_VSync and RGB out, 2-cycle latency.
module animated_pattern_gen
   import video_pkg::*;
#(
   parameter int VIDEO_WIDTH = VGA_VIDEO_WIDTH,
   parameter int TOTAL_COLS  = VGA_TOTAL_COLS,
   parameter int TOTAL_ROWS  = VGA_TOTAL_ROWS,
   parameter int ACTIVE_COLS = VGA_ACTIVE_COLS,
   parameter int ACTIVE_ROWS = VGA_ACTIVE_ROWS,
   parameter int CHECK_LOG2  = 5,
   parameter int BOX_SIZE    = 32,
   parameter int BOX_STEP    = 2
) (
   input  logic                   i_Clk,
   input  logic                   i_Rst,
   input  logic [3:0]             i_Pattern,
   input  logic                   i_HSync,
   input  logic                   i_VSync,
   output logic                   o_HSync,
   output logic                   o_VSync,
   output logic [VIDEO_WIDTH-1:0] o_Red_Video,
   output logic [VIDEO_WIDTH-1:0] o_Grn_Video,
   output logic [VIDEO_WIDTH-1:0] o_Blu_Video
);

   localparam int BAR_W  = ACTIVE_COLS / 8;
   localparam int LEVELS = 2 ** VIDEO_WIDTH;

   logic [9:0] col_q, col_d, row_q, row_d;
   logic [9:0] off_q, off_d;
   logic [7:0] fc_q;
   pat_e       pat_q;
   logic       hs1_q, vs1_q, hs2_q, vs2_q;
   logic       fs;
   logic [9:0] box_x, box_y;

   logic [VIDEO_WIDTH-1:0] red_q, grn_q, blu_q;
   logic [VIDEO_WIDTH-1:0] red_d, grn_d, blu_d;

   assign fs = i_VSync & ~vs1_q;

   always_comb begin
      col_d = col_q + 10'd1;
      row_d = row_q;
      if (fs) begin
         col_d = '0;
         row_d = '0;
      end else if (col_q == 10'(TOTAL_COLS - 1)) begin
         col_d = '0;
         row_d = (row_q == 10'(TOTAL_ROWS - 1)) ? '0 : row_q + 10'd1;
      end
   end

   // Scroll offset tracks frame_cnt mod ACTIVE_COLS without a divider;
   // it restarts whenever the 8-bit frame count wraps.
   always_comb begin
      off_d = off_q + 10'd1;
      if (fc_q == 8'hFF || off_q == 10'(ACTIVE_COLS - 1)) off_d = '0;
   end

   box_bouncer #(.LIMIT(ACTIVE_COLS - BOX_SIZE), .STEP(BOX_STEP)) u_bx (
      .clk_i(i_Clk), .rst_i(i_Rst), .step_i(fs), .pos_o(box_x)
   );

   box_bouncer #(.LIMIT(ACTIVE_ROWS - BOX_SIZE), .STEP(BOX_STEP)) u_by (
      .clk_i(i_Clk), .rst_i(i_Rst), .step_i(fs), .pos_o(box_y)
   );

   logic [2:0]             bar, sbar, on;
   logic [VIDEO_WIDTH-1:0] lvl;
   logic [10:0]            ssum;
   logic [9:0]             scol;
   logic                   active, border, in_box, ramp_en;

   // Bar and ramp indices come from constant thresholds, not division.
   always_comb begin
      bar  = '0;
      sbar = '0;
      lvl  = '0;
      ssum = {1'b0, col_q} + {1'b0, off_q};
      if (ssum >= 11'(ACTIVE_COLS)) scol = 10'(ssum - 11'(ACTIVE_COLS));
      else scol = ssum[9:0];
      for (int k = 1; k < 8; k++) begin
         if (col_q >= 10'(k * BAR_W)) bar = 3'(k);
         if (scol >= 10'(k * BAR_W)) sbar = 3'(k);
      end
      for (int k = 1; k < LEVELS; k++) begin
         if (col_q >= 10'((k * ACTIVE_COLS + LEVELS - 1) / LEVELS))
            lvl = VIDEO_WIDTH'(k);
      end
   end

   assign active = (col_q < 10'(ACTIVE_COLS)) && (row_q < 10'(ACTIVE_ROWS));
   assign border = (row_q <= 10'd1) || (row_q >= 10'(ACTIVE_ROWS - 2))
                || (col_q <= 10'd1) || (col_q >= 10'(ACTIVE_COLS - 2));
   assign in_box = (col_q >= box_x)
                && ({1'b0, col_q} < {1'b0, box_x} + 11'(BOX_SIZE))
                && (row_q >= box_y)
                && ({1'b0, row_q} < {1'b0, box_y} + 11'(BOX_SIZE));

   always_comb begin
      on      = 3'b000;
      ramp_en = 1'b0;
      case (pat_q)
         PAT_RED:    on = 3'b100;
         PAT_GRN:    on = 3'b010;
         PAT_BLU:    on = 3'b001;
         PAT_CHECK:  on = {3{col_q[CHECK_LOG2] ^ row_q[CHECK_LOG2]}};
         PAT_BARS:   on = bar_rgb(bar);
         PAT_BORDER: on = {3{border}};
         PAT_RAMP:   ramp_en = 1'b1;
         PAT_BOX:    on = {3{in_box}};
         PAT_SCROLL: on = bar_rgb(sbar);
         default:    on = 3'b000;
      endcase
      red_d = ramp_en ? lvl : {VIDEO_WIDTH{on[2]}};
      grn_d = ramp_en ? lvl : {VIDEO_WIDTH{on[1]}};
      blu_d = ramp_en ? lvl : {VIDEO_WIDTH{on[0]}};
      if (!active) begin
         red_d = '0;
         grn_d = '0;
         blu_d = '0;
      end
   end

   always_ff @(posedge i_Clk) begin
      if (i_Rst) begin
         col_q <= '0;
         row_q <= '0;
         off_q <= '0;
         fc_q  <= '0;
         pat_q <= PAT_OFF;
         hs1_q <= 1'b0;
         vs1_q <= 1'b0;
         hs2_q <= 1'b0;
         vs2_q <= 1'b0;
         red_q <= '0;
         grn_q <= '0;
         blu_q <= '0;
      end else begin
         col_q <= col_d;
         row_q <= row_d;
         hs1_q <= i_HSync;
         vs1_q <= i_VSync;
         hs2_q <= hs1_q;
         vs2_q <= vs1_q;
         red_q <= red_d;
         grn_q <= grn_d;
         blu_q <= blu_d;
         if (fs) begin
            pat_q <= pat_e'(i_Pattern);
            fc_q  <= fc_q + 8'd1;
            off_q <= off_d;
         end
      end
   end

   assign o_HSync     = hs2_q;
   assign o_VSync     = vs2_q;
   assign o_Red_Video = red_q;
   assign o_Grn_Video = grn_q;
   assign o_Blu_Video = blu_q;

endmodule

// File: tb/tb_animated_pattern_gen.sv
// Randomised bench for animated_pattern_gen on a reduced raster,
// checked cycle by cycle against a frame-level reference model.
module tb_animated_pattern_gen;

   localparam int VW   = 3;
   localparam int TC   = 18;
   localparam int TR   = 10;
   localparam int AC   = 16;
   localparam int AR   = 8;
   localparam int CL   = 1;
   localparam int BOX  = 4;
   localparam int STEP = 2;
   localparam int NCYC = 268 * TC * TR;

   logic          clk = 1'b0;
   logic          rst, hs, vs;
   logic [3:0]    pat;
   logic          o_hs, o_vs;
   logic [VW-1:0] o_r, o_g, o_b;

   always #5 clk = ~clk;

   animated_pattern_gen #(
      .VIDEO_WIDTH(VW), .TOTAL_COLS(TC), .TOTAL_ROWS(TR),
      .ACTIVE_COLS(AC), .ACTIVE_ROWS(AR), .CHECK_LOG2(CL),
      .BOX_SIZE(BOX), .BOX_STEP(STEP)
   ) dut (
      .i_Clk(clk), .i_Rst(rst), .i_Pattern(pat),
      .i_HSync(hs), .i_VSync(vs),
      .o_HSync(o_hs), .o_VSync(o_vs),
      .o_Red_Video(o_r), .o_Grn_Video(o_g), .o_Blu_Video(o_b)
   );

   int n_cmp = 0;
   int n_err = 0;

   task automatic check_eq(input string tag,
                           input logic [31:0] got,
                           input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s @%0t: got %0h want %0h", tag, $time, got, exp);
      end
   endtask

   // Reference model state: cycles since frame start, latched
   // pattern, frame count and box position/direction.
   int         k_m, pr_m, fc_m, bx_m, by_m, dx_m, dy_m;
   bit         pv_m;
   logic [10:0] s1, s2;

   function automatic logic [8:0] rgbf(input int r, g, b);
      logic [2:0] rr, gg, bb;
      rr = {3{r[0]}};
      gg = {3{g[0]}};
      bb = {3{b[0]}};
      return {rr, gg, bb};
   endfunction

   function automatic logic [8:0] pix(input int c, input int r);
      int b;
      logic [2:0] lv;
      if (c >= AC || r >= AR) return 9'd0;
      case (pr_m)
         1: return rgbf(1, 0, 0);
         2: return rgbf(0, 1, 0);
         3: return rgbf(0, 0, 1);
         4: begin
            b = ((c >> CL) ^ (r >> CL)) & 1;
            return rgbf(b, b, b);
         end
         5: begin
            b = c / (AC / 8);
            return rgbf(b >> 2, b >> 1, b);
         end
         6: begin
            b = (r <= 1 || r >= AR - 2 || c <= 1 || c >= AC - 2) ? 1 : 0;
            return rgbf(b, b, b);
         end
         7: begin
            lv = 3'(c * (2 ** VW) / AC);
            return {lv, lv, lv};
         end
         8: begin
            b = (c >= bx_m && c < bx_m + BOX &&
                 r >= by_m && r < by_m + BOX) ? 1 : 0;
            return rgbf(b, b, b);
         end
         9: begin
            b = ((c + fc_m) % AC) / (AC / 8);
            return rgbf(b >> 2, b >> 1, b);
         end
         default: return 9'd0;
      endcase
   endfunction

   task automatic bounce(inout int p, inout int d, input int lim);
      int n;
      n = p + d * STEP;
      if (n > lim) begin
         p = lim;
         d = -1;
      end else if (n < 0) begin
         p = 0;
         d = 1;
      end else begin
         p = n;
      end
   endtask

   task automatic model_edge();
      if (rst) begin
         k_m = 0; pr_m = 0; fc_m = 0;
         bx_m = 0; by_m = 0; dx_m = 1; dy_m = 1;
         pv_m = 1'b0;
         s1 = '0;
         s2 = '0;
      end else begin
         if (vs && !pv_m) begin
            k_m  = 0;
            pr_m = int'(pat);
            fc_m = (fc_m + 1) % 256;
            bounce(bx_m, dx_m, AC - BOX);
            bounce(by_m, dy_m, AR - BOX);
         end else begin
            k_m++;
         end
         pv_m = vs;
         s2 = s1;
         s1 = {hs, vs, pix(k_m % TC, (k_m / TC) % TR)};
      end
   endtask

   int bc, br, frames, nf;

   initial begin
      bc = 0; br = AR; frames = 0;
      rst = 1'b1; pat = 4'd0;
      hs = 1'b1; vs = 1'b0;
      s1 = '0; s2 = '0;
      for (int cyc = 0; cyc < NCYC; cyc++) begin
         @(posedge clk);
         model_edge();
         @(negedge clk);
         check_eq("hsync", 32'(o_hs), 32'(s2[10]));
         check_eq("vsync", 32'(o_vs), 32'(s2[9]));
         check_eq("rgb", 32'({o_r, o_g, o_b}), 32'(s2[8:0]));
         bc++;
         if (bc == TC) begin
            bc = 0;
            br = (br == TR - 1) ? 0 : br + 1;
            if (br == 0) frames++;
         end
         rst = (cyc < 2) ||
               (frames == 5 && br == AR && bc >= 3 && bc < 6);
         if (br == AR && bc == 1) begin
            nf = (fc_m + 1) % 256;
            if (frames >= 10 && frames < 32) pat = 4'd8;
            else if (nf >= 254 || nf <= 2) pat = 4'd9;
            else pat = 4'($urandom_range(0, 15));
         end else if (br < AR && !(br == 0 && bc == 0) &&
                      $urandom_range(0, 63) == 0) begin
            pat = 4'($urandom_range(0, 15));
         end
         hs = (bc < AC);
         vs = (br < AR);
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_err);
      $finish;
   end

endmodule
